// File: rtl/regfile_pkg.sv
// Register-file defaults shared with the CPU top.
// Provides the LEGv8 register-file geometry (64-bit words, 32 registers,
// XZR at index 31) and the matching address/word types. reg_file itself
// stays fully parametric and only takes its default parameters from here.
package regfile_pkg;

    localparam int REG_WIDTH = 64;
    localparam int REG_DEPTH = 32;
    localparam int XZR_IDX   = 31;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [63:0] reg_word_t;

endpackage

// File: rtl/en_reg_vec.sv
// WIDTH-bit flop vector with synchronous active-high reset and load enable.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous clear, has priority over en
//   en    - load d at the next edge
//   d     - data in
//   q     - registered data out
module en_reg_vec #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/reg_file.sv
// Parametric register file: DEPTH x WIDTH, two combinational read ports,
// one synchronous write port, optional hardwired-zero register and optional
// same-cycle write-to-read bypass.
// Ports:
//   clk, reset         - clock, synchronous active-high clear of all registers
//   wr_en/addr/data    - write port, captured at posedge clk
//   rd_addr1/rd_data1  - read port 1 (combinational)
//   rd_addr2/rd_data2  - read port 2 (combinational)
module reg_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = XZR_IDX,
    parameter int BYPASS   = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data2
);

    if (ZERO_IDX >= DEPTH) begin : g_bad_zero_idx
        $error("reg_file: ZERO_IDX must be < DEPTH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("reg_file: WIDTH must be >= 1");
    end

    localparam int NRD = 2;

    logic                             wr_ok;
    logic [DEPTH-1:0]                 wr_sel;
    logic [DEPTH-1:0][WIDTH-1:0]      regs;
    logic [NRD-1:0][AW-1:0]           rd_addr;
    logic [NRD-1:0][WIDTH-1:0]        rd_data;

    // A write is effective only outside reset, in range, and not aimed at
    // the hardwired-zero register. Bypass reuses this same qualifier.
    always_comb begin
        wr_ok = wr_en && !reset && (32'(wr_addr) < DEPTH);
        if (ZERO_EN != 0 && 32'(wr_addr) == ZERO_IDX) wr_ok = 1'b0;
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i] = wr_ok && (32'(wr_addr) == i);
        end
    end

    // The zero register has no storage at all; its slot is tied to 0.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_EN != 0 && i == ZERO_IDX) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_flop
            en_reg_vec #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (wr_sel[i]),
                .d     (wr_data),
                .q     (regs[i])
            );
        end
    end

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            if (32'(rd_addr[p]) < DEPTH) rd_data[p] = regs[rd_addr[p]];
            if (BYPASS != 0 && wr_ok && rd_addr[p] == wr_addr) rd_data[p] = wr_data;
        end
    end

    assign rd_data1 = rd_data[0];
    assign rd_data2 = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    // Four configurations share one stimulus: default, bypass, no zero reg,
    // and a non-power-of-two depth of 20.
    localparam int NI = 4;
    localparam int DEP [NI] = '{32, 32, 32, 20};
    localparam int ZE  [NI] = '{1, 1, 0, 1};
    localparam int BY  [NI] = '{0, 1, 0, 0};

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [63:0] rd1 [NI];
    logic [63:0] rd2 [NI];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [63:0] m [NI][32];

    always #5 clk = ~clk;

    reg_file u_dut (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                    .rd_addr1(rd_addr1), .rd_data1(rd1[0]), .rd_addr2(rd_addr2), .rd_data2(rd2[0]));
    reg_file #(.BYPASS(1)) u_byp (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                    .rd_addr1(rd_addr1), .rd_data1(rd1[1]), .rd_addr2(rd_addr2), .rd_data2(rd2[1]));
    reg_file #(.ZERO_EN(0)) u_nz (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                    .rd_addr1(rd_addr1), .rd_data1(rd1[2]), .rd_addr2(rd_addr2), .rd_data2(rd2[2]));
    reg_file #(.DEPTH(20), .ZERO_IDX(19), .ZERO_EN(0)) u_d20 (.clk(clk), .reset(reset), .wr_en(wr_en),
                    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_data1(rd1[3]),
                    .rd_addr2(rd_addr2), .rd_data2(rd2[3]));

    // Effective zero index per instance (u_d20 has no zero register).
    function automatic bit is_zero_reg(int k, int a);
        return ZE[k] != 0 && a == 31;
    endfunction

    function automatic bit write_takes(int k);
        return !reset && wr_en && int'(wr_addr) < DEP[k] && !is_zero_reg(k, int'(wr_addr));
    endfunction

    function automatic logic [63:0] exp_rd(int k, logic [4:0] a);
        if (int'(a) >= DEP[k]) return 64'h0;
        if (is_zero_reg(k, int'(a))) return 64'h0;
        if (BY[k] != 0 && write_takes(k) && a == wr_addr) return wr_data;
        return m[k][a];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model storage update.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                for (int a = 0; a < 32; a++) m[k][a] <= 64'h0;
            end else if (write_takes(k)) begin
                m[k][wr_addr] <= wr_data;
            end
        end
    end

    // Every-cycle compare of all read ports against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("inst%0d rd1[%0d]", k, rd_addr1), rd1[k], exp_rd(k, rd_addr1));
                check($sformatf("inst%0d rd2[%0d]", k, rd_addr2), rd2[k], exp_rd(k, rd_addr2));
            end
        end
    end

    task automatic drive(logic rst, logic we, logic [4:0] wa, logic [63:0] wd,
                         logic [4:0] ra1, logic [4:0] ra2);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = ra1; rd_addr2 = ra2;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 32; a++) m[k][a] = 64'h0;
        drive(1, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_en = 1'b1;

        // reset sweep
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 5'(a), 5'(31 - a));
            check("sweep lit", rd1[0] | rd2[0] | rd1[2] | rd2[2], 64'h0);
            tick();
        end

        // write / readback
        drive(0, 1, 5, 64'hDEADBEEF_CAFEF00D, 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 5);
        check("wr5 rd1 lit", rd1[0], 64'hDEADBEEF_CAFEF00D);
        check("wr5 rd2 lit", rd2[0], 64'hDEADBEEF_CAFEF00D);
        tick();
        drive(0, 0, 0, 0, 4, 6);
        check("reg4 lit", rd1[0], 64'h0);
        check("reg6 lit", rd2[0], 64'h0);
        tick();

        // zero register
        drive(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
        check("xzr no bypass lit", rd1[1], 64'h0);
        tick();
        drive(0, 0, 0, 0, 31, 31);
        check("xzr lit", rd1[0], 64'h0);
        check("no-zero r31 lit", rd1[2], 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // enable gating, reset priority, bypass inhibited during reset
        drive(0, 0, 7, 64'h1234, 7, 7);
        tick();
        drive(0, 0, 0, 0, 7, 5);
        check("we0 reg7 lit", rd1[0], 64'h0);
        tick();
        drive(1, 1, 7, 64'h55, 7, 5);
        check("byp in reset lit", rd1[1], 64'h0);
        tick();
        drive(0, 0, 0, 0, 7, 5);
        check("rst reg7 lit", rd1[0], 64'h0);
        check("rst reg5 lit", rd2[0], 64'h0);
        tick();

        // bypass
        drive(0, 1, 9, 64'h11, 0, 0);
        tick();
        drive(0, 1, 9, 64'h22, 9, 3);
        check("byp1 pre lit", rd1[1], 64'h22);
        check("byp0 pre lit", rd1[0], 64'h11);
        tick();
        drive(0, 0, 0, 0, 9, 9);
        check("byp1 post lit", rd1[1], 64'h22);
        check("byp0 post lit", rd1[0], 64'h22);
        tick();

        // non-power-of-two depth
        drive(0, 1, 25, 64'hAB, 0, 0);
        tick();
        drive(0, 1, 19, 64'h1919, 25, 25);
        check("d20 oob lit", rd1[3], 64'h0);
        check("d32 a25 lit", rd1[0], 64'hAB);
        tick();
        drive(0, 0, 0, 0, 19, 25);
        check("d20 r19 lit", rd1[3], 64'h1919);
        tick();

        // mixed directed traffic with a mid-sequence reset
        for (int i = 0; i < 24; i++) begin
            drive(i == 15, 1'b1, 5'(i * 7 + 3), {32'hA5A5_0000 + 32'(i), 32'(i * 3)},
                  5'(i * 7 + 3), 5'(i * 5 + 1));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
